arb_mux: RTL and testbench

ARB_MUX -- requirements
Module: arb_mux

---
 rtl/arb_mux_pkg.sv | 19 +
 rtl/arb_mux_rr_arbiter.sv | 49 ++++
 rtl/arb_mux.sv | 150 +++++++++++++++
 tb/tb_arb_mux.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/arb_mux_pkg.sv
// Shared types and helpers for the arb_mux packet arbiter.
// The ARB_MUX_RR_EN macro selects round-robin arbitration; without it, fixed priority applies.
package arb_mux_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Increment modulo n, so that non-power-of-2 channel counts wrap correctly.
    function automatic int wrap_inc(input int idx, input int n);
        if (idx >= n - 1) begin
            return 0;
        end else begin
            return idx + 1;
        end
    endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational round-robin grant: first requester at or above ptr, with wrap-around.
// Tying ptr to zero turns it into a lowest-index-first arbiter.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [N-1:0]  grant_s;
    logic [IW-1:0] idx_s;
    logic          found_s;
    logic [IW-1:0] cand_s;
    int            pos_s;

    // Scan upward from ptr and take the first valid requester.
    always_comb begin
        grant_s = '0;
        idx_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        pos_s   = 0;
        for (int off = 0; off < N; off++) begin
            pos_s = int'(ptr) + off;
            if (pos_s >= N) begin
                pos_s = pos_s - N;
            end else begin
                pos_s = pos_s;
            end
            cand_s = IW'(pos_s);
            if (!found_s && req[cand_s]) begin
                found_s        = 1'b1;
                grant_s[cand_s] = 1'b1;
                idx_s          = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign grant = grant_s;
    assign idx   = idx_s;
    assign any   = found_s;

endmodule

// File: rtl/arb_mux.sv
// Packet-aware N:1 arbiter/mux with a one-beat registered output stage.
// Define ARB_MUX_RR_EN for round-robin arbitration; default build is fixed priority.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DWIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_INPUTS-1:0]         in_valid,
    input  logic [DWIDTH-1:0]           in_data [N_INPUTS],
    input  logic [N_INPUTS-1:0]         in_last,
    output logic [N_INPUTS-1:0]         in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DWIDTH-1:0]           out_data,
    output logic                        out_last,
    output logic [$clog2(N_INPUTS)-1:0] out_src
);

    localparam int IW = $clog2(N_INPUTS);

    state_t                state_r, state_n_s;
    logic [IW-1:0]         lock_idx_r, lock_idx_n_s;
    logic [IW-1:0]         ptr_s;
    logic [N_INPUTS-1:0]   gnt_s;
    logic [IW-1:0]         gnt_idx_s;
    logic                  req_any_s;
    logic                  load_s;
    logic                  accept_s;
    logic [IW-1:0]         sel_s;
    logic [N_INPUTS-1:0]   in_ready_s;

    logic                  out_valid_r;
    logic [DWIDTH-1:0]     out_data_r;
    logic                  out_last_r;
    logic [IW-1:0]         out_src_r;

    assign load_s = !out_valid_r || out_ready;

    rr_arbiter #(
        .N  (N_INPUTS),
        .IW (IW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_s),
        .grant (gnt_s),
        .idx   (gnt_idx_s),
        .any   (req_any_s)
    );

    // Next-state, per-channel ready and beat selection.
    always_comb begin
        state_n_s    = state_r;
        lock_idx_n_s = lock_idx_r;
        in_ready_s   = '0;
        accept_s     = 1'b0;
        sel_s        = '0;
        case (state_r)
            IDLE: begin
                if (load_s && req_any_s) begin
                    in_ready_s = gnt_s;
                    sel_s      = gnt_idx_s;
                    accept_s   = 1'b1;
                    if (!in_last[gnt_idx_s]) begin
                        state_n_s    = LOCKED;
                        lock_idx_n_s = gnt_idx_s;
                    end else begin
                        state_n_s = IDLE;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            LOCKED: begin
                // Only the locked channel is eligible; it may stall forever.
                sel_s                  = lock_idx_r;
                in_ready_s[lock_idx_r] = load_s;
                accept_s               = load_s && in_valid[lock_idx_r];
                if (accept_s && in_last[lock_idx_r]) begin
                    state_n_s = IDLE;
                end else begin
                    state_n_s = LOCKED;
                end
            end
            default: begin
                state_n_s    = IDLE;
                lock_idx_n_s = '0;
            end
        endcase
    end

    // FSM state and lock index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            lock_idx_r <= '0;
        end else begin
            state_r    <= state_n_s;
            lock_idx_r <= lock_idx_n_s;
        end
    end

`ifdef ARB_MUX_RR_EN
    logic [IW-1:0] ptr_r;

    // Round-robin pointer moves past the source of each completed packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (accept_s && in_last[sel_s]) begin
            ptr_r <= IW'(wrap_inc(int'(sel_s), N_INPUTS));
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    // Output beat register: load on accept, drain on transfer, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_src_r   <= '0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[sel_s];
            out_last_r  <= in_last[sel_s];
            out_src_r   <= sel_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Ready must read zero while reset is held, even though it is combinational.
    assign in_ready  = rst_n ? in_ready_s : '0;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign out_src   = out_src_r;

endmodule

// File: tb/tb_arb_mux.sv
// Directed, table-driven bench for arb_mux (N=4) plus a short N=3 wrap sequence.
module tb_arb_mux;

`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid, in_last, in_ready;
    logic [7:0] in_data [4];
    logic       out_valid, out_ready, out_last;
    logic [7:0] out_data;
    logic [1:0] out_src;

    logic [2:0] in_valid3, in_last3, in_ready3;
    logic [7:0] in_data3 [3];
    logic       out_valid3, out_ready3, out_last3;
    logic [7:0] out_data3;
    logic [1:0] out_src3;

    int n_checks;
    int n_err;

    arb_mux #(.N_INPUTS(4), .DWIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .out_src(out_src)
    );

    arb_mux #(.N_INPUTS(3), .DWIDTH(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_data(in_data3),
        .in_last(in_last3), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_ready(out_ready3), .out_data(out_data3), .out_last(out_last3),
        .out_src(out_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] dbase;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [7:0] od;
        logic [1:0] os;
        logic       ol;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [7:0] db,
                                input logic ordy, input logic [3:0] rdy, input logic ov,
                                input logic [7:0] od, input logic [1:0] os, input logic ol);
        vec_t r;
        r.valid = v; r.last = l; r.dbase = db; r.ordy = ordy;
        r.rdy = rdy; r.ov = ov; r.od = od; r.os = os; r.ol = ol;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [7:0] db, input logic ordy);
        in_valid  = v;
        in_last   = l;
        out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i] = db + 8'(i);
    endtask

    task automatic chk_out(input string nm, input logic ov, input logic [7:0] od,
                           input logic [1:0] os, input logic ol);
        chk({nm, " out_valid"}, 32'(out_valid), 32'(ov));
        chk({nm, " out_data"},  32'(out_data),  32'(od));
        chk({nm, " out_src"},   32'(out_src),   32'(os));
        chk({nm, " out_last"},  32'(out_last),  32'(ol));
    endtask

    logic [1:0] exp3 [6];
    logic [2:0] v3   [6];

    initial begin
        n_checks = 0;
        n_err    = 0;

        // Single beats, a 3-beat lock on ch1 with ch0 waiting, backpressure, lock stall, arbitration.
        tbl[0]  = mk(4'b0001, 4'b0001, 8'hA5, 1'b1, 4'b0001, 1'b1, 8'hA5, 2'd0, 1'b1);
        tbl[1]  = mk(4'b0000, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd0, 1'b1);
        tbl[2]  = mk(4'b0100, 4'b0100, 8'h10, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2, 1'b1);
        tbl[3]  = mk(4'b0010, 4'b0000, 8'h20, 1'b1, 4'b0010, 1'b1, 8'h21, 2'd1, 1'b0);
        tbl[4]  = mk(4'b0011, 4'b0000, 8'h30, 1'b1, 4'b0010, 1'b1, 8'h31, 2'd1, 1'b0);
        tbl[5]  = mk(4'b0011, 4'b0010, 8'h40, 1'b1, 4'b0010, 1'b1, 8'h41, 2'd1, 1'b1);
        tbl[6]  = mk(4'b0001, 4'b0001, 8'h50, 1'b1, 4'b0001, 1'b1, 8'h50, 2'd0, 1'b1);
        for (int k = 7; k < 12; k++)
            tbl[k] = mk(4'b0001, 4'b0001, 8'h60, 1'b0, 4'b0000, 1'b1, 8'h50, 2'd0, 1'b1);
        tbl[12] = mk(4'b0001, 4'b0001, 8'h60, 1'b1, 4'b0001, 1'b1, 8'h60, 2'd0, 1'b1);
        tbl[13] = mk(4'b1000, 4'b0000, 8'h70, 1'b1, 4'b1000, 1'b1, 8'h73, 2'd3, 1'b0);
        tbl[14] = mk(4'b0000, 4'b0000, 8'h00, 1'b1, 4'b1000, 1'b0, 8'h73, 2'd3, 1'b0);
        tbl[15] = mk(4'b0111, 4'b0111, 8'h80, 1'b1, 4'b1000, 1'b0, 8'h73, 2'd3, 1'b0);
        tbl[16] = mk(4'b1111, 4'b1000, 8'h90, 1'b1, 4'b1000, 1'b1, 8'h93, 2'd3, 1'b1);
        tbl[17] = mk(4'b1001, 4'b1001, 8'hA0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0, 1'b1);
        tbl[18] = mk(4'b1001, 4'b1001, 8'hB0, 1'b1, RR ? 4'b1000 : 4'b0001, 1'b1,
                     RR ? 8'hB3 : 8'hB0, RR ? 2'd3 : 2'd0, 1'b1);
        tbl[19] = mk(4'b1001, 4'b1001, 8'hC0, 1'b1, 4'b0001, 1'b1, 8'hC0, 2'd0, 1'b1);
        tbl[20] = mk(4'b1111, 4'b1111, 8'hD0, 1'b1, RR ? 4'b0010 : 4'b0001, 1'b1,
                     RR ? 8'hD1 : 8'hD0, RR ? 2'd1 : 2'd0, 1'b1);
        tbl[21] = mk(4'b1111, 4'b1111, 8'hE0, 1'b1, RR ? 4'b0100 : 4'b0001, 1'b1,
                     RR ? 8'hE2 : 8'hE0, RR ? 2'd2 : 2'd0, 1'b1);
        tbl[22] = mk(4'b1111, 4'b1111, 8'hF0, 1'b1, RR ? 4'b1000 : 4'b0001, 1'b1,
                     RR ? 8'hF3 : 8'hF0, RR ? 2'd3 : 2'd0, 1'b1);
        tbl[23] = mk(4'b1111, 4'b1111, 8'h10, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1);
        tbl[24] = mk(4'b1111, 4'b1111, 8'h20, 1'b1, RR ? 4'b0010 : 4'b0001, 1'b1,
                     RR ? 8'h21 : 8'h20, RR ? 2'd1 : 2'd0, 1'b1);

        v3[0] = 3'b100; v3[1] = 3'b110; v3[2] = 3'b111;
        v3[3] = 3'b111; v3[4] = 3'b101; v3[5] = 3'b011;
        exp3[0] = 2'd2; exp3[1] = 2'd1;
        exp3[2] = RR ? 2'd2 : 2'd0; exp3[3] = 2'd0;
        exp3[4] = RR ? 2'd2 : 2'd0; exp3[5] = 2'd0;

        rst_n = 1'b0;
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);
        in_valid3 = 3'b000; in_last3 = 3'b000; out_ready3 = 1'b1;
        for (int i = 0; i < 3; i++) in_data3[i] = 8'(i + 1);
        #1;
        chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
        chk("reset in_ready", 32'(in_ready), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            drive(tbl[r].valid, tbl[r].last, tbl[r].dbase, tbl[r].ordy);
            #1;
            chk($sformatf("row%0d in_ready", r), 32'(in_ready), 32'(tbl[r].rdy));
            @(posedge clk);
            #1;
            chk_out($sformatf("row%0d", r), tbl[r].ov, tbl[r].od, tbl[r].os, tbl[r].ol);
        end

        // Reset in the middle of a ch2 packet, then a ch0 single beat 0xA5 on the first edge.
        @(negedge clk);
        drive(4'b0100, 4'b0000, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        chk_out("pre-reset", 1'b1, 8'h02, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async reset", 1'b0, 8'h00, 2'd0, 1'b0);
        chk("async reset in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'b0101, 4'b0001, 8'hA5, 1'b1);
        #1;
        chk("post-reset in_ready", 32'(in_ready), 32'h1);
        @(posedge clk);
        #1;
        chk_out("post-reset", 1'b1, 8'hA5, 2'd0, 1'b1);
        @(negedge clk);
        drive(4'b0000, 4'b0000, 8'h00, 1'b1);

        // Three-channel instance: pointer wrap after channel 2.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid3 = v3[c];
            in_last3  = v3[c];
            #1;
            chk($sformatf("n3 step%0d in_ready", c), 32'(in_ready3), 32'(3'b001 << exp3[c]));
            @(posedge clk);
            #1;
            chk($sformatf("n3 step%0d out_src", c), 32'(out_src3), 32'(exp3[c]));
            chk($sformatf("n3 step%0d out_data", c), 32'(out_data3), 32'(exp3[c]) + 32'd1);
            chk($sformatf("n3 step%0d out_valid", c), 32'(out_valid3), 32'd1);
        end
        @(negedge clk);
        in_valid3 = 3'b000;
        in_last3  = 3'b000;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
